// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART transmitter and the future receiver.
`timescale 1ns / 1ps
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    function automatic int unsigned calc_period(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

    // A bit must last at least two clocks so the divider has a distinct last count.
    function automatic bit period_ok(input int unsigned period);
        return period >= 2;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy and full flags; pushes when full and pops when
// empty are ignored.
`timescale 1ns / 1ps
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             wr_en, rd_en;
    logic [LVL_W-1:0] level_next;

    always_comb begin
        wr_en      = push && !full;
        rd_en      = pop && (level != '0);
        level_next = level + LVL_W'(wr_en) - LVL_W'(rd_en);
    end

    assign pop_data = mem[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level    <= '0;
            full     <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level <= level_next;
            full  <= (level_next == LVL_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a write FIFO feeds a start/data/parity/stop shifter that sends
// frames back-to-back whenever words are queued.
`timescale 1ns / 1ps
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FREQ      = 12000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_BITS-1:0]        in_data,
    output logic                        in_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(DEPTH+1)-1:0]  level
);

    localparam int unsigned PERIOD = calc_period(FREQ, BAUD);
    localparam int unsigned DIV_W  = $clog2(PERIOD);
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam parity_e     PAR_MODE  = parity_e'(2'(PARITY));
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PERIOD - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (!period_ok(PERIOD)) begin : g_bad_period
        $error("uart_tx_fifo: FREQ/BAUD must give at least 2 clocks per bit");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    tx_state_e              state_q;
    logic [DIV_W-1:0]       div_q;
    logic [3:0]             bit_cnt_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   par_q;

    logic                   fifo_full, fifo_has;
    logic                   push, pop, bit_end, last_stop, next_idle, par_next;
    logic [DATA_BITS-1:0]   pop_data;
    logic [LVL_W-1:0]       level_next;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .level     (level),
        .full      (fifo_full)
    );

    assign in_ready = !fifo_full;

    always_comb begin
        push       = in_valid && in_ready;
        fifo_has   = (level != '0);
        bit_end    = (div_q == DIV_LAST);
        last_stop  = (state_q == StStop) && bit_end && (bit_cnt_q == STOP_LAST);
        pop        = fifo_has && ((state_q == StIdle) || last_stop);
        level_next = level + LVL_W'(push) - LVL_W'(pop);
        next_idle  = ((state_q == StIdle) || last_stop) && !fifo_has;
        par_next   = (PAR_MODE == PAR_ODD) ? ~(^pop_data) : ^pop_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            txd       <= 1'b1;
            busy      <= 1'b0;
        end else begin
            busy <= !next_idle || (level_next != '0);
            if (pop) begin
                // Loading a word always starts a start bit, from idle or straight after a stop.
                state_q   <= StStart;
                div_q     <= '0;
                bit_cnt_q <= '0;
                shreg_q   <= pop_data;
                par_q     <= par_next;
                txd       <= 1'b0;
            end else if (state_q != StIdle) begin
                if (!bit_end) begin
                    div_q <= div_q + DIV_W'(1);
                end else begin
                    div_q <= '0;
                    case (state_q)
                        StStart: begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                            txd       <= shreg_q[0];
                            shreg_q   <= shreg_q >> 1;
                        end
                        StData: begin
                            if (bit_cnt_q == DATA_LAST) begin
                                bit_cnt_q <= '0;
                                if (PAR_MODE != PAR_NONE) begin
                                    state_q <= StParity;
                                    txd     <= par_q;
                                end else begin
                                    state_q <= StStop;
                                    txd     <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                                txd       <= shreg_q[0];
                                shreg_q   <= shreg_q >> 1;
                            end
                        end
                        StParity: begin
                            state_q   <= StStop;
                            bit_cnt_q <= '0;
                            txd       <= 1'b1;
                        end
                        StStop: begin
                            if (bit_cnt_q == STOP_LAST) begin
                                state_q <= StIdle;
                                txd     <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                        default: begin
                            state_q <= StIdle;
                            txd     <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five configurations checked cycle by cycle against a line-timeline
// model, plus frame-decoding vectors and hand-written corner sequences.
`timescale 1ns / 1ps
module tb_uart_tx_fifo;

    localparam int NDUT  = 5;
    localparam int P     = 4;
    localparam int DEPTH = 4;
    localparam int QSZ   = 512;

    int db_a  [NDUT] = '{8, 8, 8, 8, 5};
    int par_a [NDUT] = '{0, 2, 1, 1, 0};
    int sb_a  [NDUT] = '{1, 1, 1, 2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld    [NDUT];
    logic [8:0] dat    [NDUT];
    logic       txd_w  [NDUT];
    logic       busy_w [NDUT];
    logic       rdy_w  [NDUT];
    logic [2:0] lvl_w  [NDUT];

    int checks = 0;
    int errors = 0;
    bit saw_full = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.FREQ(12000000), .BAUD(3000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(dat[0][7:0]), .in_ready(rdy_w[0]),
        .txd(txd_w[0]), .busy(busy_w[0]), .level(lvl_w[0]));
    uart_tx_fifo #(.FREQ(12000000), .BAUD(3000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                   .DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(dat[1][7:0]), .in_ready(rdy_w[1]),
        .txd(txd_w[1]), .busy(busy_w[1]), .level(lvl_w[1]));
    uart_tx_fifo #(.FREQ(12000000), .BAUD(3000000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                   .DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_data(dat[2][7:0]), .in_ready(rdy_w[2]),
        .txd(txd_w[2]), .busy(busy_w[2]), .level(lvl_w[2]));
    uart_tx_fifo #(.FREQ(12000000), .BAUD(3000000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
                   .DEPTH(DEPTH)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(vld[3]), .in_data(dat[3][7:0]), .in_ready(rdy_w[3]),
        .txd(txd_w[3]), .busy(busy_w[3]), .level(lvl_w[3]));
    uart_tx_fifo #(.FREQ(12000000), .BAUD(3000000), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1),
                   .DEPTH(DEPTH)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(vld[4]), .in_data(dat[4][4:0]), .in_ready(rdy_w[4]),
        .txd(txd_w[4]), .busy(busy_w[4]), .level(lvl_w[4]));

    task automatic chk(input string nm, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: per DUT, the expected line level for each upcoming cycle. A frame is appended when
    // a word is accepted; an idle line first spends one cycle high before the start bit.
    typedef struct packed { logic txd; logic pop; logic frame; } ent_t;
    ent_t line_q [NDUT][QSZ];
    int   head [NDUT];
    int   tail [NDUT];
    int   mlvl [NDUT];

    function automatic void put(input int i, input logic b, input logic p, input logic f);
        line_q[i][tail[i] % QSZ] = '{b, p, f};
        tail[i]++;
    endfunction

    function automatic void add_frame(input int i, input logic [8:0] w);
        logic [8:0] d;
        logic       pb;
        d  = w & ((9'h1 << db_a[i]) - 9'h1);
        pb = (par_a[i] == 1) ? ~(^d) : ^d;
        for (int k = 0; k < P; k++) put(i, 1'b0, k == 0, 1'b1);
        for (int j = 0; j < db_a[i]; j++)
            for (int k = 0; k < P; k++) put(i, d[j], 1'b0, 1'b1);
        if (par_a[i] != 0)
            for (int k = 0; k < P; k++) put(i, pb, 1'b0, 1'b1);
        for (int k = 0; k < P * sb_a[i]; k++) put(i, 1'b1, 1'b0, 1'b1);
    endfunction

    initial begin
        bit         acc [NDUT];
        logic [8:0] wd  [NDUT];
        bit         rs;
        ent_t       e;
        for (int i = 0; i < NDUT; i++) begin
            head[i] = 0;
            tail[i] = 0;
            mlvl[i] = 0;
        end
        forever begin
            @(negedge clk);
            rs = rst;
            for (int i = 0; i < NDUT; i++) begin
                acc[i] = vld[i] && rdy_w[i];
                wd[i]  = dat[i];
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) begin
                if (rs) begin
                    head[i] = 0;
                    tail[i] = 0;
                    mlvl[i] = 0;
                    e = '{1'b1, 1'b0, 1'b0};
                end else begin
                    if (acc[i]) begin
                        if (head[i] == tail[i]) put(i, 1'b1, 1'b0, 1'b0);
                        add_frame(i, wd[i]);
                        mlvl[i]++;
                    end
                    if (head[i] != tail[i]) begin
                        e = line_q[i][head[i] % QSZ];
                        head[i]++;
                    end else begin
                        e = '{1'b1, 1'b0, 1'b0};
                    end
                    if (e.pop) mlvl[i]--;
                end
                chk("txd", i, int'(txd_w[i]), int'(e.txd));
                chk("level", i, int'(lvl_w[i]), mlvl[i]);
                chk("in_ready", i, int'(rdy_w[i]), int'(mlvl[i] != DEPTH));
                chk("busy", i, int'(busy_w[i]), int'(e.frame || (mlvl[i] != 0)));
            end
        end
    end

    task automatic push(input int i, input logic [8:0] w);
        int n;
        n = 0;
        vld[i] = 1'b1;
        dat[i] = w;
        while (!rdy_w[i] && n < 500) begin
            if (lvl_w[i] == 3'd4) saw_full = 1'b1;
            cyc();
            n++;
        end
        if (n >= 500) chk("push_timeout", i, n, 0);
        cyc();
        vld[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy_w[i] && n < 400) begin
            cyc();
            n++;
        end
        chk("idle_timeout", i, int'(busy_w[i]), 0);
    endtask

    // Wait for a start bit, sample each bit mid-period and measure cycles until busy drops.
    task automatic recv(input int i, output logic [8:0] data, output int parb, output int len);
        int n, c, k;
        n = 0;
        while (txd_w[i] && n < 20) begin
            cyc();
            n++;
        end
        chk("start_seen", i, int'(txd_w[i]), 0);
        data = '0;
        parb = -1;
        c    = 0;
        while (busy_w[i] && c < 200) begin
            if (c % P == 2) begin
                k = c / P;
                if (k >= 1 && k <= db_a[i]) data[k-1] = txd_w[i];
                else if (k == db_a[i] + 1 && par_a[i] != 0) parb = int'(txd_w[i]);
            end
            cyc();
            c++;
        end
        len = c;
    endtask

    typedef struct { int dut; logic [8:0] word; logic [8:0] data; int par; int len; } vec_t;

    initial begin
        vec_t       vecs [8];
        logic [8:0] rd;
        int         pb, ln, lows, rate;
        bit         rdy_pre [NDUT];
        bit         any_busy;

        vecs[0] = '{0, 9'h0A5, 9'h0A5, -1, 40};
        vecs[1] = '{1, 9'h007, 9'h007,  1, 44};
        vecs[2] = '{2, 9'h007, 9'h007,  0, 44};
        vecs[3] = '{3, 9'h007, 9'h007,  0, 48};
        vecs[4] = '{4, 9'h0FF, 9'h01F, -1, 28};
        vecs[5] = '{1, 9'h180, 9'h080,  1, 44};
        vecs[6] = '{2, 9'h000, 9'h000,  1, 44};
        vecs[7] = '{3, 9'h0FE, 9'h0FE,  0, 48};

        for (int i = 0; i < NDUT; i++) begin
            vld[i]     = 1'b0;
            dat[i]     = '0;
            rdy_pre[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        foreach (vecs[v]) begin
            push(vecs[v].dut, vecs[v].word);
            recv(vecs[v].dut, rd, pb, ln);
            chk("vec_data", vecs[v].dut, int'(rd), int'(vecs[v].data));
            chk("vec_parity", vecs[v].dut, pb, vecs[v].par);
            chk("vec_frame_len", vecs[v].dut, ln, vecs[v].len);
            cyc();
        end

        // Level reads 1 for one cycle and the start bit begins on the following edge.
        push(0, 9'h03C);
        chk("lat_level_one", 0, int'(lvl_w[0]), 1);
        chk("lat_txd_high", 0, int'(txd_w[0]), 1);
        cyc();
        chk("lat_level_zero", 0, int'(lvl_w[0]), 0);
        chk("lat_txd_fall", 0, int'(txd_w[0]), 0);
        wait_idle(0);

        // Six words with valid held: the FIFO fills and the frames run back-to-back.
        saw_full = 1'b0;
        for (int k = 0; k < 6; k++) push(0, 9'(8'h31 + k * 8'h15));
        chk("full_backpressure", 0, int'(saw_full), 1);
        wait_idle(0);

        // Reset mid-data with two words queued: nothing further is sent.
        push(0, 9'h011);
        push(0, 9'h022);
        push(0, 9'h033);
        repeat (8) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_txd", 0, int'(txd_w[0]), 1);
        chk("rst_level", 0, int'(lvl_w[0]), 0);
        chk("rst_busy", 0, int'(busy_w[0]), 0);
        chk("rst_ready", 0, int'(rdy_w[0]), 1);
        lows = 0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (!txd_w[0]) lows++;
        end
        chk("rst_no_frames", 0, lows, 0);
        push(0, 9'h05A);
        recv(0, rd, pb, ln);
        chk("rst_fresh_data", 0, int'(rd), 'h5A);
        chk("rst_fresh_len", 0, ln, 40);

        // Random traffic on all configurations, busy then sparse.
        for (int c = 0; c < 4000; c++) begin
            rate = (c < 2000) ? 3 : 60;
            for (int i = 0; i < NDUT; i++) begin
                if (!vld[i] || rdy_pre[i]) begin
                    vld[i] = ($urandom_range(0, rate) == 0);
                    dat[i] = 9'($urandom);
                end
                rdy_pre[i] = rdy_w[i];
            end
            cyc();
        end
        for (int i = 0; i < NDUT; i++) vld[i] = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            any_busy = 1'b0;
            for (int i = 0; i < NDUT; i++) any_busy |= busy_w[i];
            if (!any_busy) break;
            cyc();
        end
        for (int i = 0; i < NDUT; i++) chk("drain", i, int'(busy_w[i]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter and the next generation of the single-byte serial transmitter. Data width, parity, stop-bit count and baud are configurable, and a write FIFO with a valid/ready handshake decouples the producer from the line rate. It sits between on-chip logic (command/response path) and the board TX pin. Back-to-back frames are sent with no idle gap.

Parameters:
FREQ, 12000000, clock frequency in Hz
BAUD, 9600, line rate; PERIOD = FREQ/BAUD clk cycles per bit, integer division; PERIOD >= 2 (elaboration error otherwise)
DATA_BITS, 8, payload bits per frame, 5..9
PARITY, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, 1 or 2
DEPTH, 4, FIFO entries, power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  producer has a word
in_data  in  DATA_BITS  word to send
in_ready  out  1  FIFO not full; transfer when in_valid & in_ready at a rising edge
txd  out  1  serial line, idle high
busy  out  1  frame in progress or FIFO non-empty
level  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset values: txd=1, in_ready=1, busy=0, level=0. FIFO is flushed, shifter is IDLE, bit counter and divider are 0.
- Reset mid-frame: frame is aborted and txd=1 from the edge where rst is sampled. Queued words are discarded.
- FIFO: first-in first-out.
  - Push and pop in the same cycle leave level unchanged.
  - in_ready is registered and equals (level != DEPTH).
  - Push when not ready is ignored; the producer must hold in_valid/in_data.
  - Pointers wrap modulo DEPTH.
- Frame: start(0), DATA_BITS LSB first, parity if PARITY != 0, then STOP_BITS ones.
  - Odd parity: XOR of data bits, inverted. Even parity: XOR of data bits.
  - Every bit lasts exactly PERIOD clk cycles.
- Shifter FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE or START.
  - IDLE: if FIFO non-empty, pop and load the word; txd=0 from that edge; go START.
  - Each state advances when divider == PERIOD-1. Divider resets to 0 on every bit boundary.
  - DATA counts DATA_BITS bits. STOP counts STOP_BITS bits.
  - End of the final stop bit with FIFO non-empty: pop and go straight to START (txd=0 on that edge, no idle cycle). With FIFO empty: go IDLE with txd=1.
- Latency: word accepted into an empty FIFO with the shifter IDLE at edge E is popped at edge E+1, and txd falls at E+1. level reads 1 for exactly one cycle (after E).
- Frame length in clk cycles: PERIOD*(1+DATA_BITS+(PARITY!=0)+STOP_BITS).
- busy = (state != IDLE) | (level != 0), registered.
- txd is driven from a flop; there is no combinational path from in_* to txd.

Decomposition:
- Shared package uart_pkg:
  - parity enum PAR_NONE/PAR_ODD/PAR_EVEN;
  - shifter state enum;
  - function computing PERIOD with range assertion.
- One sub-module: sync_fifo (DEPTH, WIDTH, synchronous reset, level and full outputs), reusable by the future receiver.
- Shifter FSM, divider and parity live in uart_tx_fifo.

Test Plan:
1. FREQ=12000000, BAUD=3000000 (PERIOD=4), defaults; send 0xA5 -> txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. busy falls 40 cycles after txd falls.
2. PARITY=2, send 0x07 -> parity bit 1. PARITY=1, send 0x07 -> parity bit 0. Frame is 44 cycles. STOP_BITS=2 gives 48 cycles with the stop high for 8.
3. DEPTH=4, push 6 words with in_valid held -> in_ready low while level=4. All 6 words appear on txd in order, back-to-back: the next start bit directly follows the stop bit with no gap.
4. Push 0x3C and sample -> level=1 for exactly one cycle, and txd falls on the edge after acceptance.
5. rst for one cycle mid-data-bit with 2 words queued -> next edge txd=1, level=0, busy=0, in_ready=1. No further frames are sent, and a fresh push afterwards transmits a clean frame.
6. DATA_BITS=5, send 0x1F with extra upper bits on the bus ignored -> 7-bit frame of 28 cycles.
